// File: rtl/dcache_tag_ctrl_if.sv
// Request/response handshake bundle between the cache controller and the tag SRAM port controller.
interface dcache_tag_ctrl_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/dcache_tag_ctrl.sv
// Port controller for the single-port dcache tag SRAM: request/response handshake plus post-reset clear sweep.
// Define DCACHE_TAG_CTRL_INIT_EN to enable the clearing sweep; otherwise RUN is entered right after reset.
module dcache_tag_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dcache_tag_ctrl_if.slave      bus,
  output logic                  init_done_o,
  output logic                  sram_csb0_o,
  output logic                  sram_web0_o,
  output logic [ADDR_WIDTH-1:0] sram_addr0_o,
  output logic [DATA_WIDTH-1:0] sram_din0_o,
  input  logic [DATA_WIDTH-1:0] sram_dout0_i
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  req_ready;
  logic                  accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      idx_q        <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    resp_valid_d = resp_valid_q;
    req_ready    = 1'b0;
    accept       = 1'b0;
    init_done_o  = 1'b0;
    sram_csb0_o  = 1'b1;
    sram_web0_o  = 1'b1;
    sram_addr0_o = '0;
    sram_din0_o  = '0;

    // rst gates every strobe combinationally so nothing reaches the SRAM while held
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
`ifdef DCACHE_TAG_CTRL_INIT_EN
          sram_csb0_o  = 1'b0;
          sram_web0_o  = 1'b0;
          sram_addr0_o = idx_q[ADDR_WIDTH-1:0];
          sram_din0_o  = '0;
          idx_d        = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_RUN;
          end
`else
          state_d = ST_RUN;
`endif
        end

        ST_RUN: begin
          init_done_o = 1'b1;
          req_ready   = !(resp_valid_q && !bus.resp_ready);
          accept      = bus.req_valid && req_ready;
          if (accept) begin
            sram_csb0_o  = 1'b0;
            sram_web0_o  = !bus.req_we;
            sram_addr0_o = bus.req_addr;
            sram_din0_o  = bus.req_wdata;
          end
          // a new read overrides a completing one, so resp_valid stays high
          if (accept && !bus.req_we) begin
            resp_valid_d = 1'b1;
          end else if (resp_valid_q && bus.resp_ready) begin
            resp_valid_d = 1'b0;
          end
        end

        default: state_d = ST_INIT;
      endcase
    end
  end

  // dout is held by the macro while csb0 is high, so a stalled response stays stable
  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = sram_dout0_i;

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Scoreboard bench for dcache_tag_ctrl with a behavioural single-port tag SRAM.
module tb_dcache_tag_ctrl;
  localparam int DW = 24;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done, csb, web;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0, dout0;

  dcache_tag_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dcache_tag_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .init_done_o  (init_done),
    .sram_csb0_o  (csb),
    .sram_web0_o  (web),
    .sram_addr0_o (addr0),
    .sram_din0_o  (din0),
    .sram_dout0_i (dout0)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  logic [DW-1:0] exp_mem [16];
  logic [DW-1:0] exp_q [$];
  int total = 0;
  int bad = 0;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = {3{8'(i)}};
`ifdef DCACHE_TAG_CTRL_INIT_EN
      exp_mem[i] = '0;
`else
      exp_mem[i] = {3{8'(i)}};
`endif
    end
    dout0 = '0;
  end

  always @(posedge clk) begin
    if (!csb) begin
      if (!web) mem[addr0] <= din0;
      else      dout0      <= mem[addr0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'(bus.resp_rdata), 32'hDEAD_0000);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check("resp_rdata", 32'(bus.resp_rdata), 32'(e));
      end
    end
  end

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(bus.req_ready), 32'd1);
    if (bus.req_ready) begin
      if (we) exp_mem[a] = d;
      else    exp_q.push_back(exp_mem[a]);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    @(negedge clk);
    while (!init_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("init_done_wait", 32'(init_done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_csb", 32'(csb), 32'd1);
    check("rst_web", 32'(web), 32'd1);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    rst = 1'b0;

`ifdef DCACHE_TAG_CTRL_INIT_EN
    // first sweep interrupted at idx 7
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("sweep1_addr", 32'(addr0), 32'(i));
      check("sweep1_csb", 32'(csb), 32'd0);
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midsweep_rst_csb", 32'(csb), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("sweep_addr", 32'(addr0), 32'(i));
      check("sweep_csb", 32'(csb), 32'd0);
      check("sweep_web", 32'(web), 32'd0);
      check("sweep_din", 32'(din0), 32'd0);
      check("sweep_init_done", 32'(init_done), 32'd0);
      check("sweep_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
    end
    #1;
`else
    @(negedge clk);
    check("noinit_first_init_done", 32'(init_done), 32'd0);
    @(posedge clk);
    #1;
`endif
    check("run_init_done", 32'(init_done), 32'd1);
    check("run_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("idle_csb", 32'(csb), 32'd1);
    end
    @(posedge clk);
    #1;

    // write then read same index on consecutive cycles
    send(1'b1, 4'd3, 24'hABCDEF);
    send(1'b0, 4'd3, 24'h0);
    check("raw_resp_valid", 32'(bus.resp_valid), 32'd1);
    @(posedge clk);
    #1;
    check("raw_resp_clear", 32'(bus.resp_valid), 32'd0);

    // back-to-back reads
    send(1'b1, 4'd1, 24'h000111);
    send(1'b1, 4'd2, 24'h000222);
    send(1'b0, 4'd1, 24'h0);
    check("b2b_valid1", 32'(bus.resp_valid), 32'd1);
    send(1'b0, 4'd2, 24'h0);
    check("b2b_valid2", 32'(bus.resp_valid), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_clear", 32'(bus.resp_valid), 32'd0);

    // stalled response
    bus.resp_ready = 1'b0;
    send(1'b0, 4'd2, 24'h0);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 4'd9;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.resp_valid), 32'd1);
      check("stall_rdata", 32'(bus.resp_rdata), 32'h000222);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      check("stall_csb", 32'(csb), 32'd1);
      @(posedge clk);
    end
    #1;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("release_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("release_clear", 32'(bus.resp_valid), 32'd0);

    // write accepted while a read response handshakes
    send(1'b0, 4'd1, 24'h0);
    send(1'b1, 4'd5, 24'h5A5A5A);
    check("wr_during_hs_clear", 32'(bus.resp_valid), 32'd0);
    send(1'b0, 4'd5, 24'h0);
    send(1'b0, 4'd9, 24'h0);
    @(posedge clk);
    #1;

    // reset with a response in flight drops it
    bus.resp_ready = 1'b0;
    send(1'b0, 4'd3, 24'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    bus.resp_ready = 1'b1;
    check("rst_drop_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_drop_init_done", 32'(init_done), 32'd0);
`ifdef DCACHE_TAG_CTRL_INIT_EN
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
`endif
    wait_init();
    send(1'b0, 4'd3, 24'h0);
    send(1'b0, 4'd2, 24'h0);
    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
